// File: rtl/seq_multiplier8_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package seq_multiplier8_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_adder8.sv
// Combinational carry-lookahead adder with fully expanded carry terms.
module cla_adder8 import seq_multiplier8_pkg::*; #(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   carry;

    assign g = x & y;
    assign p = x ^ y;

    // each carry is an OR of generate terms gated by all higher propagates
    always_comb begin : lookahead
        logic term;
        carry[0] = cin;
        for (int i = 0; i < int'(WIDTH); i++) begin
            term = cin;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            carry[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                carry[i+1] = carry[i+1] | term;
            end
        end
    end

    assign sum  = p ^ carry[WIDTH-1:0];
    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_multiplier8.sv
// Unsigned shift-and-add multiplier: one partial product per clock, result with a done pulse.
module seq_multiplier8 import seq_multiplier8_pkg::*; #(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t               state, state_d;
    logic [WIDTH-1:0]     mcand, mcand_d;
    logic [2*WIDTH-1:0]   acc, acc_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [2*WIDTH-1:0]   product_d;

    logic [WIDTH-1:0]     add;
    logic [WIDTH-1:0]     sum;
    logic                 cout;
    logic [2*WIDTH-1:0]   acc_shift;

    assign add = acc[0] ? mcand : '0;

    cla_adder8 #(.WIDTH(WIDTH)) u_cla (
        .x    (acc[2*WIDTH-1:WIDTH]),
        .y    (add),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // carry out lands in the accumulator MSB so the product stays exact
    assign acc_shift = {cout, sum, acc[WIDTH-1:1]};

    always_comb begin
        state_d   = state;
        mcand_d   = mcand;
        acc_d     = acc;
        cnt_d     = cnt;
        product_d = product;
        case (state)
            IDLE: begin
                if (start) begin
                    mcand_d = a;
                    acc_d   = {WIDTH'(0), b};
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_shift;
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_d   = DONE;
                    product_d = acc_shift;
                end
            end
            DONE: begin
                if (start) begin
                    mcand_d = a;
                    acc_d   = {WIDTH'(0), b};
                    cnt_d   = '0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // status flags mirror the next state so they track the state register exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            mcand   <= mcand_d;
            acc     <= acc_d;
            cnt     <= cnt_d;
            product <= product_d;
            busy    <= (state_d == CALC);
            done    <= (state_d == DONE);
        end
    end

endmodule
